uart_rx_buffer: RTL and testbench

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
//   8N1 UART receiver feeding a first-word-fall-through FIFO.
//   The rx line is synchronized with two flops. Each byte is sampled at
//   mid-bit and pushed into the FIFO one cycle after its stop bit is
//   sampled high. A low stop bit raises a one-cycle frame_err pulse and
//   discards the byte. The receiver then waits for the line to return high,
//   so a held-low break line reports only one error.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (even, >= 8)
//   DEPTH         FIFO entries (power of 2, >= 2)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous UART line, idle high
//   rx_en      in   new frames may start while high (checked only when idle)
//   m_data     out  FIFO head byte, 0x00 while empty
//   m_valid    out  FIFO holds at least one byte
//   m_ready    in   consumer takes the head byte this cycle
//   count      out  number of bytes held, 0..DEPTH
//   frame_err  out  one-cycle pulse on a bad stop bit
//   overflow   out  sticky; a byte was dropped because the FIFO was full
module uart_rx_buffer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic                     rx_en,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic          rxSync1_q, rxSync2_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] bitCnt_q, bitCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          frameErr_q, frameErr_d;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;
  logic          doPush, doPop;

  // Two-flop synchronizer. Both flops reset to the idle-high level, so
  // leaving reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
    end else begin
      rxSync1_q <= rx;
      rxSync2_q <= rxSync1_q;
    end
  end

  // Receive FSM next-state logic.
  // START waits half a bit and confirms the line is still low; otherwise the
  // edge is treated as a glitch. From then on one sample is taken every full
  // bit period, so each sample lands near the middle of its bit.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    push_d     = 1'b0;
    frameErr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxSync2_q && rx_en) begin
          state_d  = S_START;
          bitCnt_d = '0;
        end
      end
      S_START: begin
        if (bitCnt_q == HALF_LAST) begin
          bitCnt_d = '0;
          if (!rxSync2_q) begin
            state_d  = S_DATA;
            bitIdx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bitCnt_d = bitCnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bitCnt_q == BIT_LAST) begin
          bitCnt_d = '0;
          shift_d  = {rxSync2_q, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          bitCnt_d = bitCnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (bitCnt_q == BIT_LAST) begin
          bitCnt_d = '0;
          if (rxSync2_q) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = S_WAIT_HIGH;
          end
        end else begin
          bitCnt_d = bitCnt_q + CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        if (rxSync2_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receive FSM registers. push_q delays the FIFO write by one cycle after
  // the stop-bit sample. shift_q stays stable during that cycle because the
  // FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bitCnt_q   <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
      frameErr_q <= frameErr_d;
    end
  end

  // FIFO handshake. A push into a full FIFO is still accepted when a pop
  // happens in the same cycle, because the pop frees the slot being written.
  assign m_valid = (count_q != '0);
  assign doPop   = m_valid & m_ready;
  assign doPush  = push_q & ((count_q != FULL) | doPop);

  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array. It has no reset; the count and pointers determine which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= shift_q;
    end
  end

  // Pointers, occupancy and the sticky overflow flag. DEPTH is a power of
  // two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_ONE;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_ONE;
      end
      count_q <= count_d;
      if (push_q && (count_q == FULL) && !doPop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign m_data    = m_valid ? mem_q[rdPtr_q] : 8'h00;
  assign count     = count_q;
  assign frame_err = frameErr_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer
//   Self-checking bench for uart_rx_buffer. It sends whole 8N1 frames.
//   The reference model is a byte queue plus an overflow flag and an
//   expected error count. Outputs are sampled on the falling clock edge.
module tb_uart_rx_buffer;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx;
  logic            rx_en;
  logic [7:0]      m_data;
  logic            m_valid;
  logic            m_ready;
  logic [CNTW-1:0] count;
  logic            frame_err;
  logic            overflow;

  int checks   = 0;
  int failures = 0;
  int errHigh  = 0;

  logic [7:0] modelQ[$];
  logic       modelOvf;
  int         modelErrs;

  int         lat;
  logic       seen;
  logic [7:0] pat;
  logic [7:0] lastOut;

  typedef struct {
    logic [7:0] data;
    int         expCount;
    logic       expOverflow;
    logic [7:0] expHead;
  } vec_t;

  vec_t vecs[9];

  uart_rx_buffer #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_en     (rx_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .count     (count),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count the cycles in which frame_err is high. Each bad frame should add
  // exactly one cycle.
  always @(negedge clk) begin
    if (frame_err === 1'b1) errHigh++;
  end

  // Watchdog so that a stuck run still ends with a report.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame, LSB first. The task is entered just after a falling
  // edge and returns with the line idle high.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopBit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Apply the receiver's frame rules to the model.
  task automatic modelFrame(input logic [7:0] d, input logic stopOk);
    if (!stopOk) modelErrs++;
    else if (modelQ.size() < DEPTH) modelQ.push_back(d);
    else modelOvf = 1'b1;
  endtask

  task automatic sendAndSettle(input logic [7:0] d, input logic stopOk);
    applyStimulus(d, stopOk);
    idle(4);
    modelFrame(d, stopOk);
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, " count"}, 32'(count), modelQ.size());
    checkOutput({tag, " m_valid"}, 32'(m_valid), 32'(modelQ.size() != 0));
    if (modelQ.size() != 0) checkOutput({tag, " m_data"}, 32'(m_data), 32'(modelQ[0]));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(modelOvf));
    checkOutput({tag, " frame_err cycles"}, errHigh, modelErrs);
  endtask

  task automatic popOne();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    if (modelQ.size() != 0) void'(modelQ.pop_front());
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelQ.delete();
    modelOvf = 1'b0;
  endtask

  initial begin
    // Frames 0x00..0x08 sent with no consumer: the ninth frame overflows.
    vecs[0] = '{8'h00, 1, 1'b0, 8'h00};
    vecs[1] = '{8'h01, 2, 1'b0, 8'h00};
    vecs[2] = '{8'h02, 3, 1'b0, 8'h00};
    vecs[3] = '{8'h03, 4, 1'b0, 8'h00};
    vecs[4] = '{8'h04, 5, 1'b0, 8'h00};
    vecs[5] = '{8'h05, 6, 1'b0, 8'h00};
    vecs[6] = '{8'h06, 7, 1'b0, 8'h00};
    vecs[7] = '{8'h07, 8, 1'b0, 8'h00};
    vecs[8] = '{8'h08, 8, 1'b1, 8'h00};

    rst       = 1'b1;
    rx        = 1'b1;
    rx_en     = 1'b1;
    m_ready   = 1'b0;
    modelOvf  = 1'b0;
    modelErrs = 0;
    pat       = 8'h5A;
    lat       = 0;
    seen      = 1'b0;
    lastOut   = 8'h00;

    // Reset state.
    idle(3);
    checkOutput("reset count", 32'(count), 0);
    checkOutput("reset m_valid", 32'(m_valid), 0);
    checkOutput("reset frame_err", 32'(frame_err), 0);
    checkOutput("reset overflow", 32'(overflow), 0);
    checkOutput("reset m_data", 32'(m_data), 0);
    rst = 1'b0;
    idle(4);

    // Single byte, with a latency bound measured from the falling edge.
    fork
      applyStimulus(8'hA5, 1'b1);
      begin
        lat  = 0;
        seen = 1'b0;
        while (lat < 400 && !seen) begin
          @(negedge clk);
          lat++;
          if (m_valid === 1'b1) seen = 1'b1;
        end
      end
    join
    checkOutput("A5 m_valid seen", 32'(seen), 1);
    checkOutput("A5 latency within bound", 32'(lat <= (19 * CPB) / 2 + 4), 1);
    idle(4);
    modelFrame(8'hA5, 1'b1);
    compareModel("A5");
    popOne();
    compareModel("A5 pop");

    // A short low glitch is rejected, then a real frame is received.
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(2 * CPB);
    compareModel("glitch");
    sendAndSettle(8'h3C, 1'b1);
    compareModel("3C after glitch");
    popOne();

    // A bad stop bit followed by a long break gives one error.
    applyStimulus(8'h55, 1'b0);
    rx = 1'b0;
    idle(40 * CPB);
    rx = 1'b1;
    idle(4);
    modelErrs++;
    compareModel("break");
    sendAndSettle(8'h12, 1'b1);
    compareModel("12 after break");
    popOne();

    // With rx_en low while idle, the frame is ignored.
    rx_en = 1'b0;
    applyStimulus(8'h77, 1'b1);
    idle(4);
    rx_en = 1'b1;
    compareModel("rx_en low");

    // Dropping rx_en mid-frame does not abort the frame.
    fork
      applyStimulus(8'h81, 1'b1);
      begin
        idle(40);
        rx_en = 1'b0;
      end
    join
    rx_en = 1'b1;
    idle(4);
    modelFrame(8'h81, 1'b1);
    compareModel("rx_en dropped mid-frame");
    popOne();

    // Fill past capacity from the vector table.
    for (int i = 0; i < 9; i++) begin
      sendAndSettle(vecs[i].data, 1'b1);
      checkOutput("table count", 32'(count), vecs[i].expCount);
      checkOutput("table overflow", 32'(overflow), 32'(vecs[i].expOverflow));
      checkOutput("table head", 32'(m_data), 32'(vecs[i].expHead));
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain order", 32'(m_data), i);
      popOne();
    end
    compareModel("drained");

    // Full FIFO: a push that coincides with a pop succeeds without overflow.
    doReset();
    compareModel("after reset");
    for (int i = 0; i < 8; i++) sendAndSettle(8'h10 + 8'(i), 1'b1);
    compareModel("refilled");
    fork
      applyStimulus(8'h99, 1'b1);
      begin
        repeat (155) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
      end
    join
    idle(4);
    void'(modelQ.pop_front());
    modelQ.push_back(8'h99);
    compareModel("push+pop at full");
    for (int i = 0; i < 8; i++) begin
      checkOutput("full drain data", 32'(m_data), 32'(modelQ[0]));
      lastOut = m_data;
      popOne();
    end
    checkOutput("last byte out", 32'(lastOut), 32'h99);

    // Randomized traffic checked against the model.
    for (int n = 0; n < 25; n++) begin
      logic [7:0] d;
      logic       ok;
      int         pops;
      d  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      sendAndSettle(d, ok);
      compareModel("random frame");
      pops = $urandom_range(0, 2);
      for (int p = 0; p < pops; p++) popOne();
    end
    compareModel("random end");
    for (int g = 0; g < DEPTH && modelQ.size() != 0; g++) popOne();
    compareModel("random drained");

    // Reset during data bit 4 with three bytes buffered.
    for (int i = 0; i < 3; i++) sendAndSettle(8'($urandom), 1'b1);
    compareModel("three buffered");
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = pat[i];
      idle(CPB);
    end
    rx = pat[4];
    idle(CPB / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    modelQ.delete();
    modelOvf = 1'b0;
    checkOutput("midframe reset count", 32'(count), 0);
    checkOutput("midframe reset m_valid", 32'(m_valid), 0);
    checkOutput("midframe reset overflow", 32'(overflow), 0);
    checkOutput("midframe reset frame_err", 32'(frame_err), 0);
    checkOutput("midframe reset m_data", 32'(m_data), 0);
    idle(2 * CPB);
    sendAndSettle(8'hC3, 1'b1);
    compareModel("C3 after reset");
    popOne();
    compareModel("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
